sync_frame_serializer_1101: RTL and testbench
=============================================

SYNC_FRAME_SERIALIZER_1101 -- requirements
Module: sync_frame_serializer_1101

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 Parameter SYNC_PATTERN, default 4'b1101: preamble sent MSB first ahead of every payload.
REQ-003 Parameter DATA_WIDTH, default 16: payload width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to send one frame; sampled on the rising edge of clk.
REQ-007 data_in  input  DATA_WIDTH  payload; captured on the edge that accepts start.
REQ-008 sout  output  1  registered serial bit stream.
REQ-009 bit_valid  output  1  high while sout carries a preamble or payload bit.
REQ-010 sync_phase  output  1  high while sout carries a preamble bit.
REQ-011 busy  output  1  high from the accepting edge until the last payload bit has been sent.
REQ-012 done  output  1  one-cycle pulse after the last payload bit.

Function
REQ-013 The FSM SHALL have the states IDLE, SYNC and DATA; all outputs SHALL be registered.
REQ-014 In IDLE with start=1 at edge k, the block SHALL capture data_in into a shift register, enter SYNC, and drive sout=SYNC_PATTERN[3], bit_valid=1, sync_phase=1 and busy=1 from edge k.
REQ-015 SYNC SHALL emit SYNC_PATTERN[3..0] on edges k..k+3, one bit per cycle.
REQ-016 At edge k+4 the FSM SHALL enter DATA; sync_phase SHALL drop to 0.
REQ-017 DATA SHALL emit data_in[DATA_WIDTH-1..0] MSB first on edges k+4..k+3+DATA_WIDTH (k+4..k+19 at the default).
REQ-018 A down-counter SHALL index the bits, with width ceil(log2(DATA_WIDTH)) bits; it SHALL stop at 0 and SHALL NOT wrap.
REQ-019 At edge k+4+DATA_WIDTH the FSM SHALL return to IDLE with sout=0, bit_valid=0 and busy=0, and SHALL assert done=1 for exactly that one cycle.
REQ-020 While busy=1, start SHALL be ignored and data_in changes SHALL NOT affect the frame in flight.
REQ-021 In IDLE with start=0, sout SHALL be 0 and bit_valid, sync_phase, busy and done SHALL all be 0.
REQ-022 A start held high through the done cycle SHALL be accepted on the next edge; this gives back-to-back frames with exactly one idle bit (sout=0, bit_valid=0) between them.
REQ-023 A frame SHALL occupy exactly 4+DATA_WIDTH cycles of bit_valid=1 (20 at the default).
REQ-024 The stream SHALL be such that a serial 1101 detector sampling sout while bit_valid=1 flags the preamble at its fourth bit.

Reset
REQ-025 An rst=1 sampled at an edge SHALL force IDLE and set sout=0, bit_valid=0, sync_phase=0, busy=0 and done=0; it SHALL clear the counter and the shift register.
REQ-026 Reset SHALL take priority over start on the same edge.
REQ-027 A reset in mid-frame (SYNC or DATA) SHALL abort the frame with no done pulse; the next start after rst deasserts SHALL begin a fresh preamble.

Verification
REQ-028 Reset, then one start with data_in=16'hDDDD -> sout sequence 1101 followed by 1101110111011101, bit_valid high for 20 cycles, done pulse at cycle 21.
REQ-029 data_in=16'h0000, then 16'hFFFF -> payload bits are all 0, then all 1; the preamble is unchanged at 1101.
REQ-030 Pulse start on cycle 5 of a frame while changing data_in -> the frame is unaffected and no second frame starts.
REQ-031 Hold start high continuously with data 16'hA5A5 -> frames repeat with exactly one idle bit between them, and a done pulse before each new preamble.
REQ-032 Assert rst at payload bit 7 -> outputs go to 0 on the next edge, no done pulse; a subsequent start emits a complete new frame.
REQ-033 Assert rst and start on the same edge -> the block remains in IDLE with busy=0.

Source files
------------

// File: rtl/sync_frame_serializer_1101_if.sv
// Frame serializer bus: start/payload request from the host and the registered serial stream back.
interface sync_frame_serializer_1101_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  sout;
    logic                  bit_valid;
    logic                  sync_phase;
    logic                  busy;
    logic                  done;

    modport master (
        output start, data_in,
        input  sout, bit_valid, sync_phase, busy, done
    );

    modport slave (
        input  start, data_in,
        output sout, bit_valid, sync_phase, busy, done
    );
endinterface

// File: rtl/sync_frame_serializer_1101.sv
// Sends SYNC_PATTERN MSB first, then the captured payload MSB first; all outputs are registered.
// IDLE: no frame on sout | SYNC: preamble bit on sout | DATA: payload bit on sout
module sync_frame_serializer_1101 #(
    parameter logic [3:0] SYNC_PATTERN = 4'b1101,
    parameter int         DATA_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    sync_frame_serializer_1101_if.slave  bus_if
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            sync_cnt_q, sync_cnt_d;
    logic                  sout_q, sout_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  sync_phase_q, sync_phase_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            sync_idx;

    // The counters hold the index of the bit currently on sout.
    assign sync_idx = sync_cnt_q - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            sync_cnt_q   <= '0;
            sout_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            sync_phase_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            sync_cnt_q   <= sync_cnt_d;
            sout_q       <= sout_d;
            bit_valid_q  <= bit_valid_d;
            sync_phase_q <= sync_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        sync_cnt_d   = sync_cnt_q;
        sout_d       = 1'b0;
        bit_valid_d  = 1'b0;
        sync_phase_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    state_d      = SYNC;
                    shift_d      = bus_if.data_in;
                    sync_cnt_d   = 2'd3;
                    sout_d       = SYNC_PATTERN[3];
                    bit_valid_d  = 1'b1;
                    sync_phase_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SYNC: begin
                bit_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (sync_cnt_q == 2'd0) begin
                    state_d   = DATA;
                    sout_d    = shift_q[DATA_WIDTH-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = CW'(DATA_WIDTH - 1);
                end else begin
                    sync_cnt_d   = sync_cnt_q - 2'd1;
                    sout_d       = SYNC_PATTERN[sync_idx];
                    sync_phase_d = 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    bit_cnt_d   = bit_cnt_q - CW'(1);
                    sout_d      = shift_q[DATA_WIDTH-1];
                    shift_d     = shift_q << 1;
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.sout       = sout_q;
    assign bus_if.bit_valid  = bit_valid_q;
    assign bus_if.sync_phase = sync_phase_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.done       = done_q;
endmodule

// File: tb/tb_sync_frame_serializer_1101.sv
// Scoreboard bench: stimulus queues expected bits and frame records, a negedge monitor checks them.
module tb_sync_frame_serializer_1101;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_frame_serializer_1101_if #(.DATA_WIDTH(DW)) bus ();

    sync_frame_serializer_1101 #(
        .SYNC_PATTERN(4'b1101),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus)
    );

    typedef struct {
        int len;
        bit done;
        int gap;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    frame_t     fq[$];
    logic [1:0] bq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: {sync_phase, sout} per valid bit; gap 0 means "any idle gap".
    task automatic push_frame(input logic [15:0] d, input int nbits, input bit dn, input int gap);
        logic [3:0] pat;
        pat = 4'b1101;
        for (int i = 3; i >= 0; i--) bq.push_back({1'b1, pat[i]});
        for (int i = 0; i < nbits; i++) bq.push_back({1'b0, d[15-i]});
        fq.push_back('{len: 4 + nbits, done: dn, gap: gap});
    endtask

    task automatic send(input logic [15:0] d);
        bus.start   = 1'b1;
        bus.data_in = d;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        bit         prev_v;
        int         run;
        int         idle;
        frame_t     cur;
        logic [1:0] e;
        logic       v;
        prev_v = 1'b0;
        run    = 0;
        idle   = 0;
        cur    = '{len: 0, done: 1'b0, gap: 0};
        forever begin
            @(negedge clk);
            v = bus.bit_valid;
            chk("busy_vs_valid", bus.busy, v);
            if (v && !prev_v) begin
                run = 0;
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=frame_start expected=idle at %0t", $time);
                    cur = '{len: 0, done: 1'b0, gap: 0};
                end else begin
                    cur = fq.pop_front();
                    if (cur.gap > 0) chk("idle_gap", idle, cur.gap);
                end
            end
            if (v) begin
                run++;
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit actual=valid_bit expected=none at %0t", $time);
                end else begin
                    e = bq.pop_front();
                    chk("sout", bus.sout, e[0]);
                    chk("sync_phase", bus.sync_phase, e[1]);
                end
            end else begin
                chk("idle_sout", bus.sout, 0);
                chk("idle_sync_phase", bus.sync_phase, 0);
            end
            if (!v && prev_v) begin
                chk("frame_len", run, cur.len);
                chk("done_at_end", bus.done, cur.done);
            end else begin
                chk("done_spurious", bus.done, 0);
            end
            idle   = v ? 0 : idle + 1;
            prev_v = v;
        end
    end

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_sout", bus.sout, 0);
        chk("reset_bit_valid", bus.bit_valid, 0);
        chk("reset_sync_phase", bus.sync_phase, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        push_frame(16'hDDDD, 16, 1'b1, 0);
        send(16'hDDDD);
        repeat (22) @(posedge clk);
        #1;

        push_frame(16'h0000, 16, 1'b1, 0);
        send(16'h0000);
        repeat (22) @(posedge clk);
        #1;
        push_frame(16'hFFFF, 16, 1'b1, 0);
        send(16'hFFFF);
        repeat (22) @(posedge clk);
        #1;

        // start pulse and new data mid-frame must be ignored
        push_frame(16'h1234, 16, 1'b1, 0);
        send(16'h1234);
        repeat (4) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.data_in = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = 16'h0F0F;
        repeat (25) @(posedge clk);
        #1;

        push_frame(16'hA5A5, 16, 1'b1, 0);
        push_frame(16'hA5A5, 16, 1'b1, 1);
        push_frame(16'hA5A5, 16, 1'b1, 1);
        bus.start   = 1'b1;
        bus.data_in = 16'hA5A5;
        repeat (43) @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // reset lands right after payload bit 7 has been sent: 4 + 8 bits seen, no done
        push_frame(16'hC3A5, 8, 1'b0, 0);
        send(16'hC3A5);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_bit_valid", bus.bit_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #1;
        push_frame(16'h3C3C, 16, 1'b1, 0);
        send(16'h3C3C);
        repeat (22) @(posedge clk);
        #1;

        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 16'hFFFF;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", bus.busy, 0);
        chk("rst_start_bit_valid", bus.bit_valid, 0);
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 100 && (bq.size() != 0 || fq.size() != 0); i++) @(posedge clk);
        chk("bits_left", bq.size(), 0);
        chk("frames_left", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
